mac_acc: RTL and testbench

MAC_ACC -- requirements
Module: mac_acc

---
 rtl/mac_acc.sv | 116 +++++++++++
 tb/tb_mac_acc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc.sv
// rtl/mac_acc.sv - multiply-accumulate summing N_TERMS products per result
//
// Purpose:
//   Accepts unsigned 8-bit products from an upstream 4x4 multiplier and sums
//   N_TERMS of them. The completed sum is presented with a valid/ready
//   handshake. While a result is being presented, no new products are taken.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   clr        synchronous abort; discards the partial or pending sum
//   p[7:0]     unsigned product
//   in_valid   p is valid this cycle
//   in_ready   block can accept p this cycle (depends on state only)
//   sum        completed sum; qualified only by out_valid
//   out_valid  sum is valid
//   out_ready  downstream accepts sum this cycle
//   cnt[3:0]   number of products accepted into the current sum
//
// Parameters:
//   N_TERMS    products per result, 1..16
//   ACC_W      accumulator / result width, 12 or more

module mac_acc #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       p,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       cnt
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Count value held just before the final product is accepted. cnt is only
  // four bits wide, so with N_TERMS=16 it reads 0 while the result is held.
  localparam logic [3:0] LAST_CNT = 4'(N_TERMS - 1);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [ACC_W-1:0] sum_n;
  logic [3:0]       cnt_n;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] acc_plus_p;

  assign p_ext      = {{(ACC_W-8){1'b0}}, p};
  assign acc_plus_p = acc + p_ext;

  // Handshake outputs come straight from the state register so that there is
  // no combinational path from in_valid or out_ready.
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      sum   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      sum   <= sum_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    sum_n   = sum;

    if (clr) begin
      // Abort wins over any accept or output handshake; sum keeps its old
      // value because out_valid alone qualifies it.
      state_n = ST_ACC;
      acc_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ST_ACC: begin
          if (in_valid) begin
            acc_n = acc_plus_p;
            cnt_n = cnt + 4'd1;
            if (cnt == LAST_CNT) begin
              sum_n   = acc_plus_p;
              state_n = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_n = ST_ACC;
            acc_n   = '0;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// tb/tb_mac_acc.sv - directed self-checking bench for mac_acc

module tb_mac_acc;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [7:0]  p;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] sum;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  cnt;

  logic        b_rst;
  logic        b_clr;
  logic [7:0]  b_p;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [11:0] b_sum;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [3:0]  b_cnt;

  int total;
  int bad;

  mac_acc #(.N_TERMS(4), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .clr(clr), .p(p), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .out_valid(out_valid),
    .out_ready(out_ready), .cnt(cnt)
  );

  mac_acc #(.N_TERMS(16), .ACC_W(12)) dut16 (
    .clk(clk), .rst(b_rst), .clr(b_clr), .p(b_p), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sum(b_sum), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] v);
    in_valid = 1'b1;
    p = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++;
    if (sum !== 12'd0) begin bad++; $display("FAIL reset_sum got=%0d want=0", sum); end
    total++;
    if (cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [4];
    vals = '{8'd10, 8'd12, 8'd25, 8'd60};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready[%0d] got=%0b want=1", i, in_ready); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid[%0d] got=%0b want=0", i, out_valid); end
      feed(vals[i]);
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%0b want=1", out_valid); end
    total++;
    if (sum !== 12'd107) begin bad++; $display("FAIL basic_sum got=%0d want=107", sum); end
    total++;
    if (cnt !== 4'd4) begin bad++; $display("FAIL basic_cnt got=%0d want=4", cnt); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0b want=0", out_valid); end
    total++;
    if (cnt !== 4'd0) begin bad++; $display("FAIL basic_cnt_cleared got=%0d want=0", cnt); end
    total++;
    if (sum !== 12'd107) begin bad++; $display("FAIL basic_sum_kept got=%0d want=107", sum); end
  endtask

  task automatic test_max4();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(8'd225);
    total++;
    if (sum !== 12'd900 || out_valid !== 1'b1) begin
      bad++; $display("FAIL max4_sum got=%0d valid=%0b want=900 valid=1", sum, out_valid);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_max16();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_p = 8'd225;
    for (int i = 0; i < 16; i++) tick();
    b_in_valid = 1'b0;
    total++;
    if (b_out_valid !== 1'b1) begin bad++; $display("FAIL max16_valid got=%0b want=1", b_out_valid); end
    total++;
    if (b_sum !== 12'd3600) begin bad++; $display("FAIL max16_sum got=%0d want=3600", b_sum); end
    b_out_ready = 1'b1;
    tick();
    total++;
    if (b_out_valid !== 1'b0) begin bad++; $display("FAIL max16_release got=%0b want=0", b_out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    feed(8'd10); feed(8'd10); feed(8'd10); feed(8'd20);
    in_valid = 1'b1;
    p = 8'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (sum !== 12'd50) begin bad++; $display("FAIL bp_sum[%0d] got=%0d want=50", i, sum); end
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_handshake[%0d] got in_ready=%0b out_valid=%0b want 0/1", i, in_ready, out_valid);
      end
      total++;
      if (cnt !== 4'd4) begin bad++; $display("FAIL bp_cnt[%0d] got=%0d want=4", i, cnt); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || cnt !== 4'd0) begin
      bad++; $display("FAIL bp_release got valid=%0b cnt=%0d want 0/0", out_valid, cnt);
    end
    feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
    total++;
    if (sum !== 12'd10 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_next_sum got=%0d valid=%0b want=10 valid=1", sum, out_valid);
    end
    tick();
  endtask

  task automatic test_gaps();
    logic       vpat [7];
    logic [3:0] cexp [6];
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cexp = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3};
    out_ready = 1'b0;
    p = 8'd1;
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i];
      tick();
      if (i < 6) begin
        total++;
        if (cnt !== cexp[i]) begin bad++; $display("FAIL gaps_cnt[%0d] got=%0d want=%0d", i, cnt, cexp[i]); end
      end
    end
    in_valid = 1'b0;
    total++;
    if (sum !== 12'd4 || out_valid !== 1'b1) begin
      bad++; $display("FAIL gaps_sum got=%0d valid=%0b want=4 valid=1", sum, out_valid);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_clr();
    out_ready = 1'b0;
    feed(8'd3); feed(8'd4);
    total++;
    if (cnt !== 4'd2) begin bad++; $display("FAIL clr_pre_cnt got=%0d want=2", cnt); end
    clr = 1'b1;
    in_valid = 1'b1;
    p = 8'd7;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    total++;
    if (cnt !== 4'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL clr_cnt got cnt=%0d in_ready=%0b want 0/1", cnt, in_ready);
    end
    for (int i = 0; i < 4; i++) feed(8'd5);
    total++;
    if (sum !== 12'd20 || out_valid !== 1'b1) begin
      bad++; $display("FAIL clr_sum got=%0d valid=%0b want=20 valid=1", sum, out_valid);
    end
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (out_valid !== 1'b0 || cnt !== 4'd0) begin
      bad++; $display("FAIL clr_hold got valid=%0b cnt=%0d want 0/0", out_valid, cnt);
    end
    total++;
    if (sum !== 12'd20) begin bad++; $display("FAIL clr_sum_kept got=%0d want=20", sum); end
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    feed(8'd10); feed(8'd12); feed(8'd25); feed(8'd60);
    total++;
    if (sum !== 12'd107 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rh_pre got sum=%0d valid=%0b want 107/1", sum, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rh_out_valid got=%0b want=0", out_valid); end
    total++;
    if (sum !== 12'd0) begin bad++; $display("FAIL rh_sum got=%0d want=0", sum); end
    total++;
    if (cnt !== 4'd0) begin bad++; $display("FAIL rh_cnt got=%0d want=0", cnt); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rh_in_ready got=%0b want=1", in_ready); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1; clr = 1'b0; p = '0; in_valid = 1'b0; out_ready = 1'b0;
    b_rst = 1'b1; b_clr = 1'b0; b_p = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    tick();
    b_rst = 1'b0;
    test_reset();
    test_basic();
    test_max4();
    test_max16();
    test_backpressure();
    test_gaps();
    test_clr();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
